// File: rtl/store_monitor_pkg.sv
// rtl/store_monitor_pkg.sv - shared types for the store monitor and its log FIFO
package store_monitor_pkg;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_PASS = 2'd1,
      ST_FAIL = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] pc;
   } log_entry_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/store_log_fifo.sv
// rtl/store_log_fifo.sv - store log FIFO with MSB-wrap pointers and drop indication
module store_log_fifo
   import store_monitor_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  log_entry_t push_entry,
   input  logic       pop_ready,
   output logic       head_valid,
   output log_entry_t head,
   output logic       drop
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW:0] wptr;
   logic [AW:0] rptr;
   log_entry_t  mem [DEPTH];

   logic full;
   logic empty;
   logic pop;
   logic wr;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign pop   = !empty && pop_ready;
   // A pop frees the slot this same edge, so a push into a full FIFO is legal then
   assign wr    = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (wr)  wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wptr[AW-1:0]] <= push_entry;
   end

   assign head_valid = !empty;
   assign head       = mem[rptr[AW-1:0]];

endmodule

// File: rtl/store_monitor.sv
// rtl/store_monitor.sv - watches processor stores, logs them and decides pass/fail/timeout
module store_monitor
   import store_monitor_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter logic [31:0] PASS_ADDR = 32'd84,
   parameter logic [31:0] PASS_DATA = 32'd7,
   parameter int          TIMEOUT   = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] dataadr,
   input  logic [31:0] writedata,
   input  logic [31:0] pc,
   output logic        log_valid,
   input  logic        log_ready,
   output logic [31:0] log_addr,
   output logic [31:0] log_data,
   output logic [31:0] log_pc,
   output logic        overflow,
   output logic [15:0] store_count,
   output logic        done,
   output logic        pass,
   output logic        fail,
   output logic        timeout
);

   localparam int             CW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST_CYCLE = CW'(TIMEOUT - 1);

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cycle_cnt;

   logic       in_run;
   logic       push;
   logic       hit;
   logic       good;
   logic       expire;
   logic       drop;
   log_entry_t entry;
   log_entry_t head;

   assign in_run = (state == ST_RUN);
   assign push   = in_run && memwrite;
   assign hit    = push && (dataadr == PASS_ADDR);
   assign good   = (writedata == PASS_DATA);
   // The terminating store wins over a timeout landing in the same cycle
   assign expire = in_run && !hit && (cycle_cnt == LAST_CYCLE);

   always_comb begin
      state_nxt = state;
      if (hit)
         state_nxt = good ? ST_PASS : ST_FAIL;
      else if (expire)
         state_nxt = ST_FAIL;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_RUN;
         cycle_cnt   <= '0;
         store_count <= '0;
         overflow    <= 1'b0;
         done        <= 1'b0;
         pass        <= 1'b0;
         fail        <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (in_run) cycle_cnt <= cycle_cnt + 1'b1;
         if (push)   store_count <= sat_inc16(store_count);
         if (drop)   overflow <= 1'b1;
         if (hit) begin
            done <= 1'b1;
            pass <= good;
            fail <= !good;
         end else if (expire) begin
            done    <= 1'b1;
            fail    <= 1'b1;
            timeout <= 1'b1;
         end
      end
   end

   assign entry = '{addr: dataadr, data: writedata, pc: pc};

   store_log_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_entry (entry),
      .pop_ready  (log_ready),
      .head_valid (log_valid),
      .head       (head),
      .drop       (drop)
   );

   assign log_addr = head.addr;
   assign log_data = head.data;
   assign log_pc   = head.pc;

endmodule

// File: tb/tb_store_monitor.sv
// tb/tb_store_monitor.sv - randomized scoreboard bench for store_monitor
module tb_store_monitor;

   localparam int DEPTH   = 8;
   localparam int TIMEOUT = 1024;

   logic        clk = 1'b0;
   logic        reset;
   logic        memwrite;
   logic [31:0] dataadr;
   logic [31:0] writedata;
   logic [31:0] pc;
   logic        log_valid;
   logic        log_ready;
   logic [31:0] log_addr;
   logic [31:0] log_data;
   logic [31:0] log_pc;
   logic        overflow;
   logic [15:0] store_count;
   logic        done;
   logic        pass;
   logic        fail;
   logic        timeout;

   store_monitor #(
      .DEPTH     (DEPTH),
      .PASS_ADDR (32'd84),
      .PASS_DATA (32'd7),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .memwrite    (memwrite),
      .dataadr     (dataadr),
      .writedata   (writedata),
      .pc          (pc),
      .log_valid   (log_valid),
      .log_ready   (log_ready),
      .log_addr    (log_addr),
      .log_data    (log_data),
      .log_pc      (log_pc),
      .overflow    (overflow),
      .store_count (store_count),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .timeout     (timeout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: outcome 0=running 1=passed 2=failed
   logic [95:0] exp_q[$];
   int mcount;
   int moutcome;
   int mcycles;
   int mstores;
   int movf;
   int mtimeout;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      mcount   = 0;
      moutcome = 0;
      mcycles  = 0;
      mstores  = 0;
      movf     = 0;
      mtimeout = 0;
   endtask

   task automatic chk_status();
      chk("log_valid", log_valid, mcount > 0);
      chk("store_count", store_count, mstores);
      chk("overflow", overflow, movf);
      chk("done", done, moutcome != 0);
      chk("pass", pass, moutcome == 1);
      chk("fail", fail, moutcome == 2);
      chk("timeout", timeout, mtimeout);
   endtask

   task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] p, input logic rdy);
      int pop;
      int acc;
      memwrite  = mw;
      dataadr   = a;
      writedata = d;
      pc        = p;
      log_ready = rdy;
      pop = (mcount > 0 && rdy) ? 1 : 0;
      acc = 0;
      if (moutcome == 0 && mw) begin
         if (mcount < DEPTH || pop == 1) begin
            exp_q.push_back({a, d, p});
            acc = 1;
         end else begin
            movf = 1;
         end
         if (mstores < 65535) mstores++;
      end
      mcount = mcount - pop + acc;
      if (moutcome == 0) begin
         if (mw && a == 32'd84)
            moutcome = (d == 32'd7) ? 1 : 2;
         else if (mcycles == TIMEOUT - 1) begin
            moutcome = 2;
            mtimeout = 1;
         end
         mcycles++;
      end
      @(posedge clk);
      #1;
      chk_status();
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      memwrite  = 1'b0;
      log_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom & 32'h0000_0FFC;
      if (a == 32'd84) a = 32'd88;
      return a;
   endfunction

   task automatic rand_store(input logic rdy);
      step(1'b1, rand_addr(), $urandom, $urandom, rdy);
   endtask

   task automatic drain(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
      chk("queue_drained", 96'(exp_q.size()), 96'd0);
   endtask

   // Monitor: pops the expected log whenever the DUT hands over its head
   always @(negedge clk) begin
      if (reset === 1'b1 && log_valid === 1'b1 && log_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fifo_unexpected: got %0h expected no entry", {log_addr, log_data, log_pc});
         end else begin
            chk("fifo_head", {log_addr, log_data, log_pc}, exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; memwrite = 1'b0; dataadr = '0; writedata = '0; pc = '0; log_ready = 1'b0;
      model_clear();
      repeat (2) @(posedge clk);
      #1;
      chk_status();
      reset = 1'b1;

      // Two stores ending in a passing store
      step(1'b1, 32'd80, 32'd7, 32'h44, 1'b1);
      step(1'b1, 32'd84, 32'd7, 32'h48, 1'b1);
      chk("pass_after_store", pass, 1'b1);
      chk("count_two", store_count, 16'd2);
      for (int i = 0; i < 10; i++) rand_store(1'($urandom_range(0, 1)));
      drain(4);

      // Failing store then stores that must be ignored
      do_reset();
      step(1'b1, 32'd84, 32'd5, 32'h10, 1'b1);
      for (int i = 0; i < 100; i++)
         step(1'b1, (i % 7 == 0) ? 32'd84 : rand_addr(), $urandom, $urandom, 1'($urandom_range(0, 1)));
      chk("fail_holds_count", store_count, 16'd1);
      drain(3);

      // Timeout with random traffic and random backpressure
      do_reset();
      for (int i = 0; i < TIMEOUT - 1; i++) rand_store(1'($urandom_range(0, 3) == 0));
      chk("no_fail_before_timeout", fail, 1'b0);
      rand_store(1'b0);
      chk("timeout_fail", {done, fail, timeout}, 3'b111);
      drain(DEPTH + 2);

      // Terminating store coincides with the timeout cycle
      do_reset();
      for (int i = 0; i < TIMEOUT - 1; i++) step(1'b0, 32'd0, 32'd0, 32'd0, 1'b1);
      step(1'b1, 32'd84, 32'd7, 32'h99, 1'b1);
      chk("store_beats_timeout", {pass, timeout}, 2'b10);
      drain(2);

      // Overflow: ten stores without draining
      do_reset();
      for (int i = 0; i < 10; i++) rand_store(1'b0);
      chk("overflow_set", overflow, 1'b1);
      chk("count_ten", store_count, 16'd10);
      drain(DEPTH + 2);

      // Five stores queued, then reset pulsed in the middle of a cycle
      for (int i = 0; i < 5; i++) rand_store(1'b0);
      #2;
      reset = 1'b0;
      model_clear();
      #1;
      chk("async_rst_log_valid", log_valid, 1'b0);
      chk("async_rst_count", store_count, 16'd0);
      chk("async_rst_overflow", overflow, 1'b0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      step(1'b1, 32'd84, 32'd7, 32'h5, 1'b1);
      drain(2);

      // Full FIFO with simultaneous push and pop
      do_reset();
      for (int i = 0; i < DEPTH; i++) rand_store(1'b0);
      rand_store(1'b1);
      chk("full_push_pop_no_overflow", overflow, 1'b0);
      chk("full_push_pop_count", 96'(mcount), 96'(DEPTH));
      drain(DEPTH + 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 Parameter DEPTH, 8, log FIFO entries; power of two, 2..64.
REQ-002 Parameter PASS_ADDR, 32'd84, address whose store ends the test.
REQ-003 Parameter PASS_DATA, 32'd7, data value at PASS_ADDR that means pass.
REQ-004 Parameter TIMEOUT, 1024, maximum cycles in RUN before fail.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low; 0 resets the block immediately.
REQ-007 memwrite  input  1  processor store strobe; one store per cycle while high.
REQ-008 dataadr  input  32  store byte address, qualified by memwrite.
REQ-009 writedata  input  32  store data, qualified by memwrite.
REQ-010 pc  input  32  PC of the storing instruction, qualified by memwrite.
REQ-011 log_valid  output  1  FIFO head is valid.
REQ-012 log_ready  input  1  consumer accepts head when log_valid is also 1.
REQ-013 log_addr, log_data, log_pc  output  32 each  FIFO head fields.
REQ-014 overflow  output  1  sticky; a store was dropped because the FIFO was full.
REQ-015 store_count  output  16  stores observed in RUN; saturates at 16'hFFFF.
REQ-016 done, pass, fail  output  1 each  test finished / passed / failed; all sticky.
REQ-017 timeout  output  1  sticky; qualifies fail as caused by timeout.

Function
REQ-018 FSM states: RUN, PASS, FAIL; encoded as 2 bits.
REQ-019 RUN to PASS on memwrite=1, dataadr=PASS_ADDR and writedata=PASS_DATA.
REQ-020 RUN to FAIL on memwrite=1, dataadr=PASS_ADDR and writedata other than PASS_DATA.
REQ-021 RUN to FAIL with timeout=1 when cycle_cnt reaches TIMEOUT-1 and no store to PASS_ADDR occurs in that cycle.
REQ-022 If the terminating store and the timeout occur in the same cycle, the store decides the outcome and timeout stays 0.
REQ-023 PASS and FAIL hold until reset; done=1 in both, pass=1 only in PASS, fail=1 only in FAIL.
REQ-024 Outputs pass/fail/done/timeout are registered and assert the cycle after the deciding edge.
REQ-025 cycle_cnt increments every cycle in RUN and freezes on leaving RUN.
REQ-026 Capture: in RUN, each cycle with memwrite=1 pushes {dataadr, writedata, pc}, including the terminating store; no pushes in PASS/FAIL.
REQ-027 A pushed entry is visible at the head (log_valid=1) one cycle after its capture edge when the FIFO was empty.
REQ-028 Pop occurs on the edge where log_valid and log_ready are both 1; entries leave in capture order.
REQ-029 Push while full without a same-cycle pop: entry dropped, FIFO unchanged, overflow set.
REQ-030 Push and pop in the same cycle while full: both performed, no drop, overflow unchanged.
REQ-031 Pop while empty is ignored; log_ready has no effect when log_valid=0.
REQ-032 Read and write pointers are log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; full/empty are decided by comparing their MSBs.
REQ-033 store_count increments on every RUN store, dropped ones included, and saturates at 16'hFFFF.

Reset
REQ-034 reset=0 asynchronously forces the state to RUN and clears cycle_cnt, the pointers, store_count, overflow, done, pass, fail, timeout and log_valid to 0.
REQ-035 Reset during any state, including mid-drain, discards all FIFO contents; head field values are don't-care while log_valid=0.
REQ-036 Reset is released synchronously to clk by the instantiating level; the first capture occurs on the first edge with reset=1.

Structure
REQ-037 The shared package holds the state enum (RUN, PASS, FAIL) and the log-entry packed struct {addr, data, pc}, 96 bits.
REQ-038 The FIFO is one sub-module, store_log_fifo, parameterised by DEPTH; the FSM, counters and compare logic stay in store_monitor.
REQ-039 store_monitor connects directly to the processor top's memwrite/dataadr/writedata/pc outputs; it adds no logic on the processor path.

Verification
REQ-040 Stores (addr 80, data 7, pc 0x44), then (84, 7, 0x48), log_ready=1 -> pass=1 and done=1 from the next cycle; the FIFO yields both entries in order; store_count=2.
REQ-041 Store (84, 5) -> fail=1, timeout=0, pass=0; state holds through 100 further stores, and store_count does not change.
REQ-042 No store to 84 for 1024 cycles -> fail=1 and timeout=1 on the cycle after cycle 1023; done=1.
REQ-043 log_ready=0 and 10 stores, DEPTH=8 -> 8 entries kept, overflow=1, store_count=10; drained entries are the first 8 in order.
REQ-044 FIFO full, push and pop in the same cycle -> count stays 8, overflow stays 0, the new entry becomes the last out.
REQ-045 reset=0 pulsed mid-clock while 5 entries are queued -> log_valid, store_count and overflow go to 0 immediately and the state returns to RUN.
